// File: rtl/ahb_access_arbiter_pkg.sv
// Shared constants and types for the fetch/load-store AHB-lite access arbiter.
// Holds the AHB encodings, the FSM state encoding and the two-way round-robin pick.
package ahb_access_arbiter_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  we;
    logic [2:0]            size;
  } xfer_t;

  // With both requesters eligible, the one that did not win last time gets the bus.
  function automatic grant_e pick_winner(input logic   if_elig,
                                         input logic   mem_elig,
                                         input grant_e last_grant);
    if (if_elig && mem_elig) begin
      return (last_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF;
    end else if (mem_elig) begin
      return GRANT_MEM;
    end else begin
      return GRANT_IF;
    end
  endfunction

endpackage

// File: rtl/ahb_access_arbiter.sv
// Arbitrates instruction fetch and load/store onto one AHB-lite master port,
// one non-overlapped transfer at a time (address phase, then data phase).
module ahb_access_arbiter
  import ahb_access_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch port
  input  logic                  if_req,
  input  logic [WORD_WIDTH-1:0] if_addr,
  output logic [WORD_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  output logic                  if_err,
  // load/store port
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_ack,
  output logic                  mem_err,
  // AHB-lite master
  output logic [WORD_WIDTH-1:0] haddr,
  output logic [WORD_WIDTH-1:0] hwdata,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  input  logic [WORD_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp,
  // pipeline stall
  output logic                  ahb_bus_wait
);

  state_e                state_q;
  grant_e                owner_q;
  grant_e                last_grant_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] haddr_q;
  logic [WORD_WIDTH-1:0] hwdata_q;
  logic [1:0]            htrans_q;
  logic                  hwrite_q;
  logic [2:0]            hsize_q;
  logic [WORD_WIDTH-1:0] if_rdata_q;
  logic                  if_ack_q;
  logic                  if_err_q;
  logic [WORD_WIDTH-1:0] mem_rdata_q;
  logic                  mem_ack_q;
  logic                  mem_err_q;

  logic   if_elig;
  logic   mem_elig;
  logic   any_elig;
  grant_e winner_d;
  xfer_t  xfer_d;

  // A requester being acked this cycle still has req high; it must not be re-granted.
  always_comb begin
    if_elig  = if_req  && !if_ack_q;
    mem_elig = mem_req && !mem_ack_q;
    any_elig = if_elig || mem_elig;
    winner_d = pick_winner(if_elig, mem_elig, last_grant_q);
    xfer_d   = '0;
    if (winner_d == GRANT_MEM) begin
      xfer_d.addr  = mem_addr;
      xfer_d.wdata = mem_wdata;
      xfer_d.we    = mem_we;
      xfer_d.size  = {1'b0, mem_size};
    end else begin
      xfer_d.addr  = if_addr;
      xfer_d.wdata = '0;
      xfer_d.we    = 1'b0;
      xfer_d.size  = HSIZE_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= GRANT_IF;
      last_grant_q <= GRANT_IF;
      wdata_q      <= '0;
      haddr_q      <= '0;
      hwdata_q     <= '0;
      htrans_q     <= HTRANS_IDLE;
      hwrite_q     <= 1'b0;
      hsize_q      <= HSIZE_WORD;
      if_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      mem_rdata_q  <= '0;
      mem_ack_q    <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      if_err_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      mem_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            state_q      <= ST_ADDR;
            owner_q      <= winner_d;
            last_grant_q <= winner_d;
            wdata_q      <= xfer_d.wdata;
            haddr_q      <= xfer_d.addr;
            hwrite_q     <= xfer_d.we;
            hsize_q      <= xfer_d.size;
            htrans_q     <= HTRANS_NONSEQ;
          end
        end
        ST_ADDR: begin
          if (hready) begin
            state_q  <= ST_DATA;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= wdata_q;
          end
        end
        ST_DATA: begin
          // An error response with hready low is just another wait state.
          if (hready) begin
            state_q <= ST_IDLE;
            if (owner_q == GRANT_MEM) begin
              mem_rdata_q <= hrdata;
              mem_ack_q   <= 1'b1;
              mem_err_q   <= hresp;
            end else begin
              if_rdata_q <= hrdata;
              if_ack_q   <= 1'b1;
              if_err_q   <= hresp;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          htrans_q <= HTRANS_IDLE;
        end
      endcase
    end
  end

  assign haddr     = haddr_q;
  assign hwdata    = hwdata_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_err   = mem_err_q;

  assign ahb_bus_wait = (if_req && !if_ack_q) || (mem_req && !mem_ack_q);

endmodule

// File: tb/tb_ahb_access_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a
// transfer-level reference model of the arbiter.
module tb_ahb_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_err;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        ahb_bus_wait;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  ahb_access_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_ack       (if_ack),
    .if_err       (if_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err),
    .haddr        (haddr),
    .hwdata       (hwdata),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .hsize        (hsize),
    .hrdata       (hrdata),
    .hready       (hready),
    .hresp        (hresp),
    .ahb_bus_wait (ahb_bus_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one outstanding transfer that completes on its second hready=1 cycle.
  bit          m_busy;
  bit          m_who_mem;
  bit          m_last_mem;
  int          m_ready_seen;
  logic [31:0] m_wdata;
  logic [31:0] m_haddr;
  logic [31:0] m_hwdata;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_if_rdata;
  logic        m_if_ack;
  logic        m_if_err;
  logic [31:0] m_mem_rdata;
  logic        m_mem_ack;
  logic        m_mem_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_busy       = 0;
    m_who_mem    = 0;
    m_last_mem   = 0;
    m_ready_seen = 0;
    m_wdata      = '0;
    m_haddr      = '0;
    m_hwdata     = '0;
    m_htrans     = 2'b00;
    m_hwrite     = 1'b0;
    m_hsize      = 3'b010;
    m_if_rdata   = '0;
    m_if_ack     = 1'b0;
    m_if_err     = 1'b0;
    m_mem_rdata  = '0;
    m_mem_ack    = 1'b0;
    m_mem_err    = 1'b0;
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_step();
    bit e_if;
    bit e_mem;
    e_if      = if_req  && !m_if_ack;
    e_mem     = mem_req && !m_mem_ack;
    m_if_ack  = 1'b0;
    m_if_err  = 1'b0;
    m_mem_ack = 1'b0;
    m_mem_err = 1'b0;
    if (m_busy) begin
      if (hready) begin
        if (m_ready_seen == 0) begin
          m_ready_seen = 1;
          m_htrans     = 2'b00;
          m_hwdata     = m_wdata;
        end else begin
          m_busy = 0;
          if (m_who_mem) begin
            m_mem_ack = 1'b1; m_mem_err = hresp; m_mem_rdata = hrdata;
          end else begin
            m_if_ack = 1'b1; m_if_err = hresp; m_if_rdata = hrdata;
          end
        end
      end
    end else if (e_if || e_mem) begin
      m_who_mem    = (e_if && e_mem) ? !m_last_mem : e_mem;
      m_last_mem   = m_who_mem;
      m_busy       = 1;
      m_ready_seen = 0;
      m_htrans     = 2'b10;
      if (m_who_mem) begin
        m_haddr = mem_addr; m_hwrite = mem_we; m_hsize = {1'b0, mem_size}; m_wdata = mem_wdata;
      end else begin
        m_haddr = if_addr; m_hwrite = 1'b0; m_hsize = 3'b010; m_wdata = '0;
      end
    end
  endtask

  task automatic model_check();
    chk("htrans",    32'(htrans),    32'(m_htrans));
    chk("haddr",     haddr,          m_haddr);
    chk("hwrite",    32'(hwrite),    32'(m_hwrite));
    chk("hsize",     32'(hsize),     32'(m_hsize));
    chk("hwdata",    hwdata,         m_hwdata);
    chk("if_ack",    32'(if_ack),    32'(m_if_ack));
    chk("if_err",    32'(if_err),    32'(m_if_err));
    chk("if_rdata",  if_rdata,       m_if_rdata);
    chk("mem_ack",   32'(mem_ack),   32'(m_mem_ack));
    chk("mem_err",   32'(mem_err),   32'(m_mem_err));
    chk("mem_rdata", mem_rdata,      m_mem_rdata);
    chk("ack_overlap", 32'(if_ack & mem_ack), 32'd0);
  endtask

  initial begin
    bit if_pend;
    bit mem_pend;
    bit cont;
    rst_n = 1'b0; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_size = 2'b00;
    mem_addr = '0; mem_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_hwrite", 32'(hwrite), 32'h0);
    chk("rst_hsize", 32'(hsize), 32'h2);
    chk("rst_acks", 32'({if_ack, if_err, mem_ack, mem_err}), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst_n = 1'b1;

    // Fetch only, ack at T+3
    if_req = 1; if_addr = 32'h100; hrdata = 32'h13;
    tick();
    chk("f_htrans_ns", 32'(htrans), 32'h2);
    chk("f_haddr", haddr, 32'h100);
    chk("f_hsize", 32'(hsize), 32'h2);
    chk("f_hwrite", 32'(hwrite), 32'h0);
    tick();
    chk("f_htrans_idle", 32'(htrans), 32'h0);
    chk("f_ack_early", 32'(if_ack), 32'h0);
    tick();
    chk("f_ack", 32'(if_ack), 32'h1);
    chk("f_rdata", if_rdata, 32'h13);
    chk("f_err", 32'(if_err), 32'h0);
    chk("f_wait_ack", 32'(ahb_bus_wait), 32'h0);
    if_req = 0;
    tick();
    chk("f_ack_pulse", 32'(if_ack), 32'h0);
    chk("f_no_regrant", 32'(htrans), 32'h0);
    chk("f_rdata_hold", if_rdata, 32'h13);

    // Store with two DATA wait states, ack at T+5
    mem_req = 1; mem_we = 1; mem_size = 2'b01; mem_addr = 32'h2000_0004; mem_wdata = 32'hBEEF;
    tick();
    chk("s_htrans", 32'(htrans), 32'h2);
    chk("s_haddr", haddr, 32'h2000_0004);
    chk("s_hsize", 32'(hsize), 32'h1);
    chk("s_hwrite", 32'(hwrite), 32'h1);
    chk("s_wait", 32'(ahb_bus_wait), 32'h1);
    mem_wdata = 32'h1234; mem_addr = 32'h0; mem_size = 2'b10;
    tick();
    chk("s_hwdata", hwdata, 32'hBEEF);
    chk("s_htrans_idle", 32'(htrans), 32'h0);
    hready = 0;
    tick();
    chk("s_ack_w1", 32'(mem_ack), 32'h0);
    chk("s_hwdata_w1", hwdata, 32'hBEEF);
    tick();
    chk("s_ack_w2", 32'(mem_ack), 32'h0);
    chk("s_hsize_w2", 32'(hsize), 32'h1);
    hready = 1;
    tick();
    chk("s_ack", 32'(mem_ack), 32'h1);
    chk("s_err", 32'(mem_err), 32'h0);
    mem_req = 0;
    tick();
    chk("s_ack_pulse", 32'(mem_ack), 32'h0);

    // Load with error response across a wait state
    mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h40; hrdata = 32'hDEAD_0000;
    tick();
    tick();
    hready = 0; hresp = 1;
    tick();
    chk("e_ack_wait", 32'(mem_ack), 32'h0);
    chk("e_err_wait", 32'(mem_err), 32'h0);
    hready = 1;
    tick();
    chk("e_ack", 32'(mem_ack), 32'h1);
    chk("e_err", 32'(mem_err), 32'h1);
    chk("e_rdata", mem_rdata, 32'hDEAD_0000);
    mem_req = 0; hresp = 0;
    tick();
    chk("e_err_clear", 32'(mem_err), 32'h0);
    chk("e_rdata_hold", mem_rdata, 32'hDEAD_0000);

    // Reset during DATA abandons the fetch, which restarts after release
    if_req = 1; if_addr = 32'h300; hrdata = 32'h55;
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("r_htrans", 32'(htrans), 32'h0);
    chk("r_haddr", haddr, 32'h0);
    chk("r_if_rdata", if_rdata, 32'h0);
    tick();
    chk("r_no_ack", 32'(if_ack), 32'h0);
    rst_n = 1;
    tick();
    chk("r_restart", 32'(htrans), 32'h2);
    chk("r_restart_addr", haddr, 32'h300);
    tick();
    tick();
    chk("r_ack", 32'(if_ack), 32'h1);
    chk("r_rdata", if_rdata, 32'h55);
    if_req = 0;
    tick();

    // Simultaneous requests after reset: mem first, fetch in the mem_ack cycle
    rst_n = 0;
    tick();
    rst_n = 1;
    if_req = 1; if_addr = 32'h400; mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h800;
    hrdata = 32'h77;
    #1;
    chk("t_wait0", 32'(ahb_bus_wait), 32'h1);
    tick();
    chk("t_mem_first", haddr, 32'h800);
    tick();
    tick();
    chk("t_mem_ack", 32'(mem_ack), 32'h1);
    chk("t_if_noack", 32'(if_ack), 32'h0);
    chk("t_wait_mid", 32'(ahb_bus_wait), 32'h1);
    mem_req = 0;
    tick();
    chk("t_if_grant", 32'(htrans), 32'h2);
    chk("t_if_addr", haddr, 32'h400);
    chk("t_wait_if", 32'(ahb_bus_wait), 32'h1);
    tick();
    tick();
    chk("t_if_ack", 32'(if_ack), 32'h1);
    chk("t_if_rdata", if_rdata, 32'h77);
    if_req = 0;

    // Randomized traffic: continuous requests first, then sporadic
    rst_n = 0;
    tick();
    model_reset();
    rst_n = 1;
    if_pend = 0; mem_pend = 0;
    for (int i = 0; i < 1500; i++) begin
      model_check();
      cont = (i < 600);
      if (m_if_ack) begin
        if_pend = 0; if_req = 1'($urandom_range(0, 1));
      end else if (!if_pend) begin
        if_pend = cont || ($urandom_range(0, 1) == 1); if_req = if_pend;
      end
      if (m_mem_ack) begin
        mem_pend = 0; mem_req = 1'($urandom_range(0, 1));
      end else if (!mem_pend) begin
        mem_pend = cont || ($urandom_range(0, 1) == 1); mem_req = mem_pend;
      end
      if_addr   = $urandom & 32'hFFFF_FFFC;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_we    = 1'($urandom_range(0, 1));
      mem_size  = 2'($urandom_range(0, 2));
      hrdata    = $urandom;
      hready    = ($urandom_range(0, 3) != 0);
      hresp     = ($urandom_range(0, 4) == 0);
      #1;
      chk("bus_wait", 32'(ahb_bus_wait),
          32'((if_req && !m_if_ack) || (mem_req && !m_mem_ack)));
      model_step();
      @(posedge clk);
      #1;
    end
    model_check();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
